// File: rtl/arb_pkg.sv
// Shared definitions for the arbiter request queue.
// Provides the client count, client index enumeration and the wait-counter type.
package arb_pkg;

  // Number of clients feeding the arbiter.
  localparam int N_REQ = 3;

  // Client indices. Also used as bit positions in the packed request and grant vectors.
  typedef enum logic [1:0] {
    CLI_A,
    CLI_B,
    CLI_C
  } client_e;

  // Per-client count of consecutive denied cycles. Saturates at WAIT_SAT.
  typedef logic [1:0] wait_cnt_t;
  localparam wait_cnt_t WAIT_SAT = 2'd3;

endpackage

// File: rtl/arb_req_fifo.sv
// Single-client transaction FIFO for the arbiter request queue.
// The FIFO state (EMPTY, PARTIAL or FULL) is carried entirely by the count register.
// Ports:
//   clk, rst   clock; synchronous active-high reset
//   push       write push_data at the tail (ignored when full)
//   push_data  payload to enqueue
//   pop        drop the head entry (ignored when empty)
//   head_data  current head entry
//   empty      count == 0
//   full       count == DEPTH
//   count      number of stored entries, 0..DEPTH
module arb_req_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [DATA_W-1:0]       push_data,
  input  logic                    pop,
  output logic [DATA_W-1:0]       head_data,
  output logic                    empty,
  output logic                    full,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW:0]       count_q, count_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              do_push, do_pop;

  // Guard both operations so the count can never run past DEPTH or below zero,
  // even if the caller misbehaves.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers are exactly log2(DEPTH) bits wide, so incrementing them wraps on their own.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // The storage has no reset. Entries are only visible through count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign empty     = (count_q == '0);
  assign full      = (count_q == (PW+1)'(DEPTH));
  assign count     = count_q;

endmodule

// File: rtl/arb_req_queue.sv
// Upstream feeder for a 3-way arbiter.
// Each client (A, B, C) has its own FIFO. A non-empty FIFO raises its request.
// A granted head is popped and forwarded in the same cycle.
// The block also watches the arbiter for protocol violations and for starvation.
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   inX_valid/ready/data     client X enqueue handshake (X = A, B, C)
//   requestX                 to arbiter: X FIFO is non-empty
//   grantX                   from arbiter: combinational answer to requestX
//   issueX_valid/data        granted head of X, forwarded this cycle
//   protocol_err             sticky: grant without request, or all three grants at once
//   starve_err               sticky: a head was denied for more than MAX_WAIT cycles
module arb_req_queue
  import arb_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inA_valid,
  output logic              inA_ready,
  input  logic [DATA_W-1:0] inA_data,
  input  logic              inB_valid,
  output logic              inB_ready,
  input  logic [DATA_W-1:0] inB_data,
  input  logic              inC_valid,
  output logic              inC_ready,
  input  logic [DATA_W-1:0] inC_data,
  output logic              requestA,
  output logic              requestB,
  output logic              requestC,
  input  logic              grantA,
  input  logic              grantB,
  input  logic              grantC,
  output logic              issueA_valid,
  output logic [DATA_W-1:0] issueA_data,
  output logic              issueB_valid,
  output logic [DATA_W-1:0] issueB_data,
  output logic              issueC_valid,
  output logic [DATA_W-1:0] issueC_data,
  output logic              protocol_err,
  output logic              starve_err
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [N_REQ-1:0]  valid_v, ready_v, push_v, req_v, grant_v, pop_v;
  logic [N_REQ-1:0]  empty_v, full_v;
  logic [DATA_W-1:0] in_data [N_REQ];
  logic [DATA_W-1:0] head_data [N_REQ];
  logic [CW-1:0]     count_v [N_REQ];

  wait_cnt_t wait_q [N_REQ];
  wait_cnt_t wait_d [N_REQ];
  logic      protocol_err_q, protocol_err_d;
  logic      starve_err_q, starve_err_d;

  assign valid_v = {inC_valid, inB_valid, inA_valid};
  assign grant_v = {grantC, grantB, grantA};
  assign in_data[CLI_A] = inA_data;
  assign in_data[CLI_B] = inB_data;
  assign in_data[CLI_C] = inC_data;

  for (genvar i = 0; i < N_REQ; i++) begin : g_cli
    // Readiness and request come from registered FIFO state only.
    // A pop in the same cycle cannot make room for a push, and a push
    // cannot bypass to the arbiter. Both are forced low during reset,
    // so entries being flushed are never offered or issued.
    assign ready_v[i] = !rst && (count_v[i] < CW'(DEPTH));
    assign req_v[i]   = !rst && !empty_v[i];
    assign push_v[i]  = valid_v[i] && ready_v[i];
    assign pop_v[i]   = grant_v[i] && req_v[i];

    arb_req_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push_v[i]),
      .push_data (in_data[i]),
      .pop       (pop_v[i]),
      .head_data (head_data[i]),
      .empty     (empty_v[i]),
      .full      (full_v[i]),
      .count     (count_v[i])
    );

    full_matches_count : assert property (@(posedge clk) full_v[i] == (count_v[i] == CW'(DEPTH)));
  end

  // The wait counter measures how long a head has been continuously denied.
  // The flags compare the registered counters, so an over-long wait
  // shows up one edge after the counter crosses MAX_WAIT.
  always_comb begin
    protocol_err_d = protocol_err_q | (|(grant_v & ~req_v)) | (&grant_v);
    starve_err_d   = starve_err_q;
    for (int i = 0; i < N_REQ; i++) begin
      if (!req_v[i] || grant_v[i]) begin
        wait_d[i] = '0;
      end else if (wait_q[i] != WAIT_SAT) begin
        wait_d[i] = wait_q[i] + wait_cnt_t'(1);
      end else begin
        wait_d[i] = wait_q[i];
      end
      if (wait_q[i] > wait_cnt_t'(MAX_WAIT)) begin
        starve_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_REQ; i++) begin
        wait_q[i] <= '0;
      end
      protocol_err_q <= 1'b0;
      starve_err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        wait_q[i] <= wait_d[i];
      end
      protocol_err_q <= protocol_err_d;
      starve_err_q   <= starve_err_d;
    end
  end

  assign inA_ready    = ready_v[CLI_A];
  assign inB_ready    = ready_v[CLI_B];
  assign inC_ready    = ready_v[CLI_C];
  assign requestA     = req_v[CLI_A];
  assign requestB     = req_v[CLI_B];
  assign requestC     = req_v[CLI_C];
  assign issueA_valid = pop_v[CLI_A];
  assign issueB_valid = pop_v[CLI_B];
  assign issueC_valid = pop_v[CLI_C];
  assign issueA_data  = head_data[CLI_A];
  assign issueB_data  = head_data[CLI_B];
  assign issueC_data  = head_data[CLI_C];
  assign protocol_err = protocol_err_q;
  assign starve_err   = starve_err_q;

endmodule

// File: tb/tb_arb_req_queue.sv
// Directed, table-driven bench for arb_req_queue.
// Each vector row gives one cycle: the inputs to apply and the outputs expected mid-cycle.
// Bit 0 of each packed vector is client A, bit 1 is B, bit 2 is C.
module tb_arb_req_queue;

  localparam int DATA_W = 8;
  localparam int DC     = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              inA_valid, inB_valid, inC_valid;
  logic              inA_ready, inB_ready, inC_ready;
  logic [DATA_W-1:0] inA_data, inB_data, inC_data;
  logic              requestA, requestB, requestC;
  logic              grantA, grantB, grantC;
  logic              issueA_valid, issueB_valid, issueC_valid;
  logic [DATA_W-1:0] issueA_data, issueB_data, issueC_data;
  logic              protocol_err, starve_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  arb_req_queue #(
    .DATA_W   (DATA_W),
    .DEPTH    (4),
    .MAX_WAIT (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .inA_valid    (inA_valid),
    .inA_ready    (inA_ready),
    .inA_data     (inA_data),
    .inB_valid    (inB_valid),
    .inB_ready    (inB_ready),
    .inB_data     (inB_data),
    .inC_valid    (inC_valid),
    .inC_ready    (inC_ready),
    .inC_data     (inC_data),
    .requestA     (requestA),
    .requestB     (requestB),
    .requestC     (requestC),
    .grantA       (grantA),
    .grantB       (grantB),
    .grantC       (grantC),
    .issueA_valid (issueA_valid),
    .issueA_data  (issueA_data),
    .issueB_valid (issueB_valid),
    .issueB_data  (issueB_data),
    .issueC_valid (issueC_valid),
    .issueC_data  (issueC_data),
    .protocol_err (protocol_err),
    .starve_err   (starve_err)
  );

  // In perr and serr, the value DC means "do not check this cycle".
  typedef struct {
    logic              rstIn;
    logic [2:0]        valid;
    logic [DATA_W-1:0] dA, dB, dC;
    logic [2:0]        grant;
    logic [2:0]        rdy, req, iss;
    logic [DATA_W-1:0] iA, iB, iC;
    int                perr, serr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic [2:0] v, logic [7:0] a, logic [7:0] b, logic [7:0] c,
                              logic [2:0] g, logic [2:0] rdy, logic [2:0] req, logic [2:0] iss,
                              logic [7:0] ia, logic [7:0] ib, logic [7:0] ic, int pe, int se);
    vec_t t;
    t.rstIn = r; t.valid = v; t.dA = a; t.dB = b; t.dC = c; t.grant = g;
    t.rdy = rdy; t.req = req; t.iss = iss; t.iA = ia; t.iB = ib; t.iC = ic;
    t.perr = pe; t.serr = se;
    return t;
  endfunction

  task automatic compare(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst       = v.rstIn;
    inA_valid = v.valid[0]; inB_valid = v.valid[1]; inC_valid = v.valid[2];
    inA_data  = v.dA;       inB_data  = v.dB;       inC_data  = v.dC;
    grantA    = v.grant[0]; grantB    = v.grant[1]; grantC    = v.grant[2];
  endtask

  task automatic checkOutput(input vec_t v, input string tag);
    compare({tag, ".ready"}, {5'b0, inC_ready, inB_ready, inA_ready}, {5'b0, v.rdy});
    compare({tag, ".request"}, {5'b0, requestC, requestB, requestA}, {5'b0, v.req});
    compare({tag, ".issue"}, {5'b0, issueC_valid, issueB_valid, issueA_valid}, {5'b0, v.iss});
    if (v.iss[0]) compare({tag, ".issueA_data"}, issueA_data, v.iA);
    if (v.iss[1]) compare({tag, ".issueB_data"}, issueB_data, v.iB);
    if (v.iss[2]) compare({tag, ".issueC_data"}, issueC_data, v.iC);
    if (v.perr != DC) compare({tag, ".protocol_err"}, {7'b0, protocol_err}, 8'(v.perr));
    if (v.serr != DC) compare({tag, ".starve_err"}, {7'b0, starve_err}, 8'(v.serr));
  endtask

  // Inputs change just after posedge. Outputs are checked at negedge.
  task automatic runVec(input vec_t v, input string tag);
    applyStimulus(v);
    @(negedge clk);
    checkOutput(v, tag);
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut(input string tag);
    runVec(mk(1, 0, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 0, 0, 0, DC, DC), {tag, ".rst0"});
    runVec(mk(1, 0, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 0, 0, 0, 0, 0), {tag, ".rst1"});
  endtask

  initial begin
    // Cases 1, 3 and 2 as one continuous table.
    // B is deliberately starved in the last part of the table.
    tbl.push_back(mk(0, 3'b001, 8'h11, 0, 0, 3'b000, 3'b111, 3'b000, 3'b000, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3'b000, 0, 0, 0, 3'b001, 3'b111, 3'b001, 3'b001, 8'h11, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3'b000, 0, 0, 0, 3'b000, 3'b111, 3'b000, 3'b000, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3'b111, 8'hA1, 8'hB1, 8'hC1, 3'b000, 3'b111, 3'b000, 3'b000, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3'b000, 0, 0, 0, 3'b011, 3'b111, 3'b111, 3'b011, 8'hA1, 8'hB1, 0, 0, 0));
    tbl.push_back(mk(0, 3'b000, 0, 0, 0, 3'b100, 3'b111, 3'b100, 3'b100, 0, 0, 8'hC1, 0, 0));
    tbl.push_back(mk(0, 3'b000, 0, 0, 0, 3'b000, 3'b111, 3'b000, 3'b000, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3'b000, 0, 0, 0, 3'b000, 3'b111, 3'b000, 3'b000, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3'b010, 0, 8'h20, 0, 3'b000, 3'b111, 3'b000, 3'b000, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3'b010, 0, 8'h21, 0, 3'b000, 3'b111, 3'b010, 3'b000, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3'b010, 0, 8'h22, 0, 3'b000, 3'b111, 3'b010, 3'b000, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3'b010, 0, 8'h23, 0, 3'b000, 3'b111, 3'b010, 3'b000, 0, 0, 0, 0, DC));
    tbl.push_back(mk(0, 3'b000, 0, 0, 0, 3'b010, 3'b101, 3'b010, 3'b010, 0, 8'h20, 0, 0, 1));
    tbl.push_back(mk(0, 3'b000, 0, 0, 0, 3'b010, 3'b111, 3'b010, 3'b010, 0, 8'h21, 0, 0, 1));
    tbl.push_back(mk(0, 3'b000, 0, 0, 0, 3'b010, 3'b111, 3'b010, 3'b010, 0, 8'h22, 0, 0, 1));
    tbl.push_back(mk(0, 3'b000, 0, 0, 0, 3'b010, 3'b111, 3'b010, 3'b010, 0, 8'h23, 0, 0, 1));
    tbl.push_back(mk(0, 3'b000, 0, 0, 0, 3'b000, 3'b111, 3'b000, 3'b000, 0, 0, 0, 0, 1));

    resetDut("init");
    for (int i = 0; i < tbl.size(); i++) begin
      runVec(tbl[i], $sformatf("vec%0d", i));
    end

    // Case 4: C is denied for two cycles in a row; the flag then stays set.
    resetDut("t4");
    runVec(mk(0, 3'b100, 0, 0, 8'hC4, 3'b000, 3'b111, 3'b000, 3'b000, 0, 0, 0, 0, 0), "t4c1");
    runVec(mk(0, 3'b000, 0, 0, 0, 3'b000, 3'b111, 3'b100, 3'b000, 0, 0, 0, 0, 0), "t4c2");
    runVec(mk(0, 3'b000, 0, 0, 0, 3'b000, 3'b111, 3'b100, 3'b000, 0, 0, 0, 0, DC), "t4c3");
    runVec(mk(0, 3'b000, 0, 0, 0, 3'b000, 3'b111, 3'b100, 3'b000, 0, 0, 0, 0, DC), "t4c4");
    runVec(mk(0, 3'b000, 0, 0, 0, 3'b100, 3'b111, 3'b100, 3'b100, 0, 0, 8'hC4, 0, 1), "t4c5");
    runVec(mk(0, 3'b000, 0, 0, 0, 3'b000, 3'b111, 3'b000, 3'b000, 0, 0, 0, 0, 1), "t4c6");
    runVec(mk(0, 3'b000, 0, 0, 0, 3'b000, 3'b111, 3'b000, 3'b000, 0, 0, 0, 0, 1), "t4c7");

    // Case 5a: a grant while B is empty is ignored but flagged.
    resetDut("t5a");
    runVec(mk(0, 3'b000, 0, 0, 0, 3'b010, 3'b111, 3'b000, 3'b000, 0, 0, 0, 0, 0), "t5c1");
    runVec(mk(0, 3'b000, 0, 0, 0, 3'b000, 3'b111, 3'b000, 3'b000, 0, 0, 0, 1, 0), "t5c2");
    runVec(mk(0, 3'b010, 0, 8'hB5, 0, 3'b000, 3'b111, 3'b000, 3'b000, 0, 0, 0, 1, 0), "t5c3");
    runVec(mk(0, 3'b000, 0, 0, 0, 3'b010, 3'b111, 3'b010, 3'b010, 0, 8'hB5, 0, 1, 0), "t5c4");
    runVec(mk(0, 3'b000, 0, 0, 0, 3'b000, 3'b111, 3'b000, 3'b000, 0, 0, 0, 1, 0), "t5c5");

    // Case 5b: three grants at once are flagged even though all three were requested.
    resetDut("t5b");
    runVec(mk(0, 3'b111, 8'h51, 8'h52, 8'h53, 3'b000, 3'b111, 3'b000, 3'b000, 0, 0, 0, 0, 0), "t5d1");
    runVec(mk(0, 3'b000, 0, 0, 0, 3'b111, 3'b111, 3'b111, 3'b111, 8'h51, 8'h52, 8'h53, 0, 0), "t5d2");
    runVec(mk(0, 3'b000, 0, 0, 0, 3'b000, 3'b111, 3'b000, 3'b000, 0, 0, 0, 1, 0), "t5d3");

    // Case 6: a push and a pop in the same cycle leave count unchanged,
    // and a mid-stream reset flushes the queued entries.
    resetDut("t6");
    runVec(mk(0, 3'b001, 8'h61, 0, 0, 3'b000, 3'b111, 3'b000, 3'b000, 0, 0, 0, 0, DC), "t6c1");
    runVec(mk(0, 3'b001, 8'h62, 0, 0, 3'b000, 3'b111, 3'b001, 3'b000, 0, 0, 0, 0, DC), "t6c2");
    runVec(mk(0, 3'b001, 8'h63, 0, 0, 3'b000, 3'b111, 3'b001, 3'b000, 0, 0, 0, 0, DC), "t6c3");
    runVec(mk(0, 3'b001, 8'h64, 0, 0, 3'b001, 3'b111, 3'b001, 3'b001, 8'h61, 0, 0, 0, DC), "t6c4");
    runVec(mk(0, 3'b000, 0, 0, 0, 3'b000, 3'b111, 3'b001, 3'b000, 0, 0, 0, 0, DC), "t6c5");
    runVec(mk(0, 3'b000, 0, 0, 0, 3'b001, 3'b111, 3'b001, 3'b001, 8'h62, 0, 0, 0, DC), "t6c6");
    runVec(mk(1, 3'b000, 0, 0, 0, 3'b001, 3'b000, 3'b000, 3'b000, 0, 0, 0, DC, DC), "t6rst");
    runVec(mk(0, 3'b000, 0, 0, 0, 3'b001, 3'b111, 3'b000, 3'b000, 0, 0, 0, 0, 0), "t6c7");
    runVec(mk(0, 3'b001, 8'h70, 0, 0, 3'b000, 3'b111, 3'b000, 3'b000, 0, 0, 0, DC, 0), "t6c8");
    runVec(mk(0, 3'b000, 0, 0, 0, 3'b001, 3'b111, 3'b001, 3'b001, 8'h70, 0, 0, DC, 0), "t6c9");
    runVec(mk(0, 3'b000, 0, 0, 0, 3'b000, 3'b111, 3'b000, 3'b000, 0, 0, 0, DC, 0), "t6c10");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
